// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART byte
// transmitter between N requesters, with burst limit and stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned N         = 2,
    parameter int unsigned MAX_BURST = 0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic [7:0]     data_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic           timeout_err_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_q;
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;
    logic [15:0]   stall_q;
    logic [15:0]   stall_d;
    logic          timeout_err_q;

    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          busy;
    logic          xfer;
    logic          burst_hit;
    logic          tmo_hit;

    // Index that is k steps after base, wrapping at N.
    function automatic logic [IW-1:0] rr_idx(
        input logic [IW-1:0] base,
        input int unsigned   k
    );
        logic [31:0] s;
        s = 32'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return s[IW-1:0];
    endfunction

    // First requesting index scanning circularly after the last owner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!pick_vld && req_valid_i[rr_idx(last_q, k)]) begin
                pick_vld = 1'b1;
                pick     = rr_idx(last_q, k);
            end
        end
    end

    assign busy = (state_q == GRANT);

    // Owner's byte stream passes straight through; others never see ready.
    always_comb begin
        data_o      = '0;
        valid_o     = 1'b0;
        req_ready_o = '0;
        if (busy) begin
            data_o               = req_data_i[{owner_q, 3'b000} +: 8];
            valid_o              = req_valid_i[owner_q];
            req_ready_o[owner_q] = ready_i;
        end
    end

    assign xfer = valid_o && ready_i;

    // Saturating next values of the byte and stall counters.
    always_comb begin
        cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        stall_d   = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        burst_hit = (MAX_BURST != 0) && (32'(cnt_d) >= MAX_BURST);
        tmo_hit   = (TIMEOUT != 0) && (32'(stall_d) >= TIMEOUT);
    end

    // Grant FSM: arbitrate in IDLE, hold until last, burst limit or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_q        <= IW'(N - 1);
            cnt_q         <= '0;
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q       <= GRANT;
                        grant_q       <= '0;
                        grant_q[pick] <= 1'b1;
                        owner_q       <= pick;
                        cnt_q         <= '0;
                        stall_q       <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        stall_q <= '0;
                        if (req_last_i[owner_q] || burst_hit) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            last_q  <= owner_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else if (tmo_hit) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        last_q        <= owner_q;
                        cnt_q         <= '0;
                        stall_q       <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = busy;
    assign timeout_err_o = timeout_err_q;

endmodule
